ellipse_raster_engine: RTL and testbench

//  Parametrised midpoint ellipse rasteriser. Takes centre (cx,cy) and radii (a,b) via start/busy/done,

---
 rtl/ellipse_raster_if.sv | 30 +++
 rtl/ellipse_raster_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ellipse_raster_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ellipse_raster_if.sv
// Handshake bundle for the ellipse rasteriser: start/abort/busy/done control,
// centre/radii operands and the valid/ready pixel stream.
//   master : drives start, abort, operands, pix_ready (producer of jobs)
//   slave  : the engine; drives busy, done, pix_valid, pix_x, pix_y
interface ellipse_raster_if #(
    parameter int COORD_W = 10
);
    logic               start;
    logic               abort;
    logic [COORD_W-1:0] cx_in;
    logic [COORD_W-1:0] cy_in;
    logic [COORD_W-1:0] a_in;
    logic [COORD_W-1:0] b_in;
    logic               busy;
    logic               done;
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;

    modport master (
        output start, abort, cx_in, cy_in, a_in, b_in, pix_ready,
        input  busy, done, pix_valid, pix_x, pix_y
    );

    modport slave (
        input  start, abort, cx_in, cy_in, a_in, b_in, pix_ready,
        output busy, done, pix_valid, pix_x, pix_y
    );
endinterface

// File: rtl/ellipse_raster_engine.sv
// Midpoint ellipse rasteriser with 4-quadrant symmetric, screen-clipped,
// backpressured pixel output, abort and degenerate-radius handling.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   bus_io : slave side of ellipse_raster_if (start/abort/operands in,
//            busy/done out, pix_valid/pix_x/pix_y out, pix_ready in)
module ellipse_raster_engine #(
    parameter int COORD_W = 10,
    parameter int ACC_W   = 3*COORD_W+4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic            clk,
    input  logic            rst,
    ellipse_raster_if.slave bus_io
);
    localparam int CW2 = COORD_W + 2;
    localparam logic signed [CW2-1:0]   X_MAX = CW2'(H_RES - 1);
    localparam logic signed [CW2-1:0]   Y_MAX = CW2'(V_RES - 1);
    localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT0,
        S_INIT1,
        S_R1,
        S_P0,
        S_P1,
        S_P2,
        S_R2,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic [COORD_W-1:0] a_q, a_d;
    logic [COORD_W-1:0] b_q, b_d;
    logic [COORD_W-1:0] ex_q, ex_d;
    logic [COORD_W-1:0] ey_q, ey_d;
    logic [1:0]         slot_q, slot_d;
    logic               in_r2_q, in_r2_d;

    logic signed [ACC_W-1:0] a2_q, a2_d;
    logic signed [ACC_W-1:0] b2_q, b2_d;
    logic signed [ACC_W-1:0] x_q, x_d;
    logic signed [ACC_W-1:0] y_q, y_d;
    logic signed [ACC_W-1:0] px_q, px_d;
    logic signed [ACC_W-1:0] py_q, py_d;
    logic signed [ACC_W-1:0] d_q, d_d;
    logic signed [ACC_W-1:0] t0_q, t0_d;
    logic signed [ACC_W-1:0] t1_q, t1_d;

    logic signed [ACC_W-1:0] a_ext, b_ext;
    logic signed [ACC_W-1:0] px_n, py_n, sq_x, sq_y, prod;

    logic signed [CW2-1:0] cx_s, cy_s, ex_s, ey_s;
    logic signed [CW2-1:0] cand_x, cand_y;
    logic                  skip, clip, valid, emit_adv;

    assign a_ext = {{(ACC_W-COORD_W){1'b0}}, a_q};
    assign b_ext = {{(ACC_W-COORD_W){1'b0}}, b_q};

    // State register (FSM state plus all datapath registers)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            slot_q  <= '0;
            in_r2_q <= 1'b0;
            a2_q    <= '0;
            b2_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            d_q     <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            slot_q  <= slot_d;
            in_r2_q <= in_r2_d;
            a2_q    <= a2_d;
            b2_q    <= b2_d;
            x_q     <= x_d;
            y_q     <= y_d;
            px_q    <= px_d;
            py_q    <= py_d;
            d_q     <= d_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        a_d     = a_q;
        b_d     = b_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        slot_d  = slot_q;
        in_r2_d = in_r2_q;
        a2_d    = a2_q;
        b2_d    = b2_q;
        x_d     = x_q;
        y_d     = y_q;
        px_d    = px_q;
        py_d    = py_q;
        d_d     = d_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        px_n    = px_q + (b2_q <<< 1);
        py_n    = py_q - (a2_q <<< 1);
        sq_x    = (x_q <<< 1) + ONE;
        sq_y    = y_q - ONE;
        prod    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus_io.start && !bus_io.abort) begin
                    cx_d    = bus_io.cx_in;
                    cy_d    = bus_io.cy_in;
                    a_d     = bus_io.a_in;
                    b_d     = bus_io.b_in;
                    state_d = S_INIT0;
                end
            end
            S_INIT0: begin
                a2_d    = a_ext * a_ext;
                b2_d    = b_ext * b_ext;
                x_d     = '0;
                y_d     = b_ext;
                px_d    = '0;
                in_r2_d = 1'b0;
                state_d = S_INIT1;
            end
            S_INIT1: begin
                prod    = a2_q * b_ext;
                py_d    = prod <<< 1;
                d_d     = (b2_q <<< 2) - (prod <<< 2) + a2_q;
                state_d = S_R1;
            end
            S_R1: begin
                if (b_q == '0) begin
                    // Flat ellipse: plain horizontal run x = 0..a on y = 0
                    if (x_q <= a_ext) begin
                        ex_d    = x_q[COORD_W-1:0];
                        ey_d    = '0;
                        x_d     = x_q + ONE;
                        slot_d  = '0;
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (px_q < py_q) begin
                    ex_d   = x_q[COORD_W-1:0];
                    ey_d   = y_q[COORD_W-1:0];
                    slot_d = '0;
                    x_d    = x_q + ONE;
                    px_d   = px_n;
                    if (d_q[ACC_W-1]) begin
                        d_d = d_q + ((px_n + b2_q) <<< 2);
                    end else begin
                        y_d  = y_q - ONE;
                        py_d = py_n;
                        d_d  = d_q + ((px_n - py_n + b2_q) <<< 2);
                    end
                    state_d = S_EMIT;
                end else begin
                    state_d = S_P0;
                end
            end
            // Region-2 seed: squares, then scaled products, then sum
            S_P0: begin
                t0_d    = sq_x * sq_x;
                t1_d    = sq_y * sq_y;
                state_d = S_P1;
            end
            S_P1: begin
                t0_d    = b2_q * t0_q;
                t1_d    = a2_q * t1_q;
                state_d = S_P2;
            end
            S_P2: begin
                prod    = a2_q * b2_q;
                d_d     = t0_q + (t1_q <<< 2) - (prod <<< 2);
                in_r2_d = 1'b1;
                state_d = S_R2;
            end
            S_R2: begin
                if (!y_q[ACC_W-1]) begin
                    ex_d   = x_q[COORD_W-1:0];
                    ey_d   = y_q[COORD_W-1:0];
                    slot_d = '0;
                    y_d    = y_q - ONE;
                    py_d   = py_n;
                    if (!d_q[ACC_W-1] && d_q != '0) begin
                        d_d = d_q + ((a2_q - py_n) <<< 2);
                    end else begin
                        x_d  = x_q + ONE;
                        px_d = px_n;
                        d_d  = d_q + ((px_n - py_n + a2_q) <<< 2);
                    end
                    state_d = S_EMIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_EMIT: begin
                if (emit_adv) begin
                    slot_d = slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        state_d = in_r2_q ? S_R2 : S_R1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a pending handshake
        if (bus_io.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // Outputs: candidate generation, skip/clip and stream signals
    always_comb begin
        cx_s   = signed'({2'b00, cx_q});
        cy_s   = signed'({2'b00, cy_q});
        ex_s   = signed'({2'b00, ex_q});
        ey_s   = signed'({2'b00, ey_q});
        // slot bit 0 mirrors x, slot bit 1 mirrors y
        cand_x = slot_q[0] ? (cx_s - ex_s) : (cx_s + ex_s);
        cand_y = slot_q[1] ? (cy_s - ey_s) : (cy_s + ey_s);
        skip   = (slot_q[0] && ex_q == '0) || (slot_q[1] && ey_q == '0);
        clip   = cand_x[CW2-1] || cand_y[CW2-1] ||
                 (cand_x > X_MAX) || (cand_y > Y_MAX);
        valid  = (state_q == S_EMIT) && !skip && !clip;
        emit_adv = !valid || bus_io.pix_ready;

        bus_io.pix_valid = valid;
        bus_io.pix_x     = valid ? cand_x[COORD_W-1:0] : '0;
        bus_io.pix_y     = valid ? cand_y[COORD_W-1:0] : '0;
        bus_io.busy      = (state_q != S_IDLE);
        bus_io.done      = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_ellipse_raster_engine.sv
// Self-checking bench for ellipse_raster_engine: reference model of the
// midpoint outline plus quadrant/clip expansion, randomized backpressure.
module tb_ellipse_raster_engine;
    localparam int CW = 10;
    localparam int H  = 640;
    localparam int V  = 480;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ellipse_raster_if #(.COORD_W(CW)) bus_if ();

    ellipse_raster_engine #(.COORD_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    int got_q[$];
    int exp_q[$];
    int done_cnt;
    int stall_bad;
    int first_lat;
    logic busy_after;
    logic done_after;

    function automatic int pk(int x, int y);
        return x * 4096 + y;
    endfunction

    function automatic void add_pt(int cx, int cy, longint x, longint y);
        for (int s = 0; s < 4; s++) begin
            longint qx;
            longint qy;
            bit     skip;
            qx   = cx + ((s % 2 == 1) ? -x : x);
            qy   = cy + ((s >= 2) ? -y : y);
            skip = ((s % 2 == 1) && x == 0) || ((s >= 2) && y == 0);
            if (!skip && qx >= 0 && qx < H && qy >= 0 && qy < V)
                exp_q.push_back(pk(int'(qx), int'(qy)));
        end
    endfunction

    function automatic void build(int cx, int cy, int a, int b);
        longint a2, b2, x, y, px, py, d;
        exp_q.delete();
        a2 = longint'(a) * a;
        b2 = longint'(b) * b;
        if (b == 0) begin
            for (int i = 0; i <= a; i++) add_pt(cx, cy, i, 0);
            return;
        end
        x = 0; y = b; px = 0; py = 2 * a2 * b;
        d = 4 * b2 - 4 * a2 * b + a2;
        while (px < py) begin
            add_pt(cx, cy, x, y);
            x++; px += 2 * b2;
            if (d < 0) d += 4 * (px + b2);
            else begin
                y--; py -= 2 * a2;
                d += 4 * (px - py + b2);
            end
        end
        d = b2 * (2 * x + 1) * (2 * x + 1) + 4 * a2 * (y - 1) * (y - 1)
            - 4 * a2 * b2;
        while (y >= 0) begin
            add_pt(cx, cy, x, y);
            y--; py -= 2 * a2;
            if (d > 0) d += 4 * (a2 - py);
            else begin
                x++; px += 2 * b2;
                d += 4 * (px - py + a2);
            end
        end
    endfunction

    // Index of first disagreement between got_q and exp_q, -1 when equal
    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] != exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Runs one job from IDLE; returns with the DUT back in IDLE
    task automatic draw(input int cx, input int cy, input int a,
                        input int b, input bit rnd);
        int   cyc;
        bit   fin;
        bit   stl;
        logic [CW-1:0] hx, hy;
        got_q.delete();
        done_cnt = 0; stall_bad = 0; first_lat = -1;
        fin = 0; stl = 0; hx = '0; hy = '0;
        bus_if.start = 1'b1;
        bus_if.cx_in = CW'(cx);
        bus_if.cy_in = CW'(cy);
        bus_if.a_in  = CW'(a);
        bus_if.b_in  = CW'(b);
        bus_if.pix_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        cyc = 1;
        while (!fin) begin
            bus_if.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stl && (!bus_if.pix_valid || bus_if.pix_x !== hx ||
                        bus_if.pix_y !== hy))
                stall_bad++;
            if (bus_if.pix_valid && first_lat < 0) first_lat = cyc;
            if (bus_if.pix_valid && bus_if.pix_ready)
                got_q.push_back(pk(int'(bus_if.pix_x), int'(bus_if.pix_y)));
            stl = bus_if.pix_valid && !bus_if.pix_ready;
            hx  = bus_if.pix_x;
            hy  = bus_if.pix_y;
            if (bus_if.done) begin
                done_cnt++;
                fin = 1;
            end
            if (rnd) begin
                bus_if.cx_in = CW'($urandom);
                bus_if.cy_in = CW'($urandom);
                bus_if.a_in  = CW'($urandom);
                bus_if.b_in  = CW'($urandom);
                bus_if.start = !bus_if.done && bus_if.busy &&
                               ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 40000) fin = 1;
        end
        bus_if.start = 1'b0;
        bus_if.pix_ready = 1'b1;
        @(posedge clk); #1;
        busy_after = bus_if.busy;
        done_after = bus_if.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.pix_ready = 1'b1;
        bus_if.cx_in = '0; bus_if.cy_in = '0;
        bus_if.a_in = '0; bus_if.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus_if.busy);
        else n_pass++;
        n_total++;
        if (bus_if.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus_if.done);
        else n_pass++;
        n_total++;
        if (bus_if.pix_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_if.pix_valid);
        else n_pass++;
        n_total++;
        if (bus_if.pix_x !== '0) $display("FAIL reset_x: got %0d want 0", bus_if.pix_x);
        else n_pass++;
        n_total++;
        if (bus_if.pix_y !== '0) $display("FAIL reset_y: got %0d want 0", bus_if.pix_y);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int k;
        int fd;
        bus_if.start = 1'b1;
        bus_if.cx_in = 10'd200; bus_if.cy_in = 10'd200;
        bus_if.a_in = 10'd20; bus_if.b_in = 10'd15;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        k = 0;
        while (!bus_if.pix_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        n_total++;
        if (!bus_if.pix_valid) $display("FAIL midreset_reach: valid %b want 1", bus_if.pix_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus_if.busy, bus_if.done, bus_if.pix_valid} !== 3'b000 ||
            bus_if.pix_x !== '0 || bus_if.pix_y !== '0)
            $display("FAIL midreset_outputs: busy/done/valid %b%b%b x %0d y %0d want all 0",
                     bus_if.busy, bus_if.done, bus_if.pix_valid, bus_if.pix_x, bus_if.pix_y);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (bus_if.busy !== 1'b0) $display("FAIL midreset_idle: busy %b want 0", bus_if.busy);
        else n_pass++;
        draw(10, 10, 2, 2, 0);
        build(10, 10, 2, 2);
        fd = first_diff();
        n_total++;
        if (fd != -1)
            $display("FAIL midreset_redraw: got %0d px diff@%0d want %0d px",
                     got_q.size(), fd, exp_q.size());
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL midreset_done: got %0d pulses want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_basic();
        int xs[12] = '{100, 100, 101, 99, 101, 99, 102, 98, 102, 98, 103, 97};
        int ys[12] = '{102, 98, 102, 102, 98, 98, 101, 101, 99, 99, 100, 100};
        int fd;
        draw(100, 100, 3, 2, 0);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(pk(xs[i], ys[i]));
        fd = first_diff();
        n_total++;
        if (fd != -1)
            $display("FAIL basic_seq: got %0d px diff@%0d want %0d px",
                     got_q.size(), fd, exp_q.size());
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt);
        else n_pass++;
        n_total++;
        if (first_lat < 1 || first_lat > 7)
            $display("FAIL basic_latency: got %0d cycles want 1..7", first_lat);
        else n_pass++;
        n_total++;
        if (busy_after !== 1'b0 || done_after !== 1'b0)
            $display("FAIL basic_after: busy %b done %b want 0 0", busy_after, done_after);
        else n_pass++;
    endtask

    // Shape checks against the model: degenerate radii and screen edges
    task automatic test_shapes();
        int cxs[6] = '{5, 20, 300, 0, 639, 2};
        int cys[6] = '{5, 20, 200, 0, 479, 470};
        int as[6]  = '{0, 4, 0, 3, 5, 7};
        int bs[6]  = '{0, 0, 5, 2, 4, 12};
        int fd;
        for (int t = 0; t < 6; t++) begin
            draw(cxs[t], cys[t], as[t], bs[t], 0);
            build(cxs[t], cys[t], as[t], bs[t]);
            fd = first_diff();
            n_total++;
            if (fd != -1)
                $display("FAIL shape%0d_seq: got %0d px diff@%0d want %0d px",
                         t, got_q.size(), fd, exp_q.size());
            else n_pass++;
            n_total++;
            if (done_cnt != 1) $display("FAIL shape%0d_done: got %0d want 1", t, done_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int fd;
        draw(320, 240, 100, 60, 1);
        build(320, 240, 100, 60);
        fd = first_diff();
        n_total++;
        if (fd != -1)
            $display("FAIL bp_seq: got %0d px diff@%0d want %0d px",
                     got_q.size(), fd, exp_q.size());
        else n_pass++;
        n_total++;
        if (stall_bad != 0) $display("FAIL bp_stable: got %0d changes want 0", stall_bad);
        else n_pass++;
        n_total++;
        if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int cx, cy, a, b, fd;
        for (int t = 0; t < 6; t++) begin
            cx = int'($urandom_range(0, 700));
            cy = int'($urandom_range(0, 520));
            a  = int'($urandom_range(0, 40));
            b  = int'($urandom_range(0, 40));
            draw(cx, cy, a, b, 1);
            build(cx, cy, a, b);
            fd = first_diff();
            n_total++;
            if (fd != -1)
                $display("FAIL rand%0d_seq (%0d,%0d,%0d,%0d): got %0d px diff@%0d want %0d px",
                         t, cx, cy, a, b, got_q.size(), fd, exp_q.size());
            else n_pass++;
            n_total++;
            if (stall_bad != 0 || done_cnt != 1)
                $display("FAIL rand%0d_ctrl: stalls %0d done %0d want 0 1",
                         t, stall_bad, done_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int n, k, bad_done, bad_busy;
        bus_if.start = 1'b1;
        bus_if.cx_in = 10'd100; bus_if.cy_in = 10'd100;
        bus_if.a_in = 10'd10; bus_if.b_in = 10'd8;
        bus_if.pix_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        n = 0; k = 0;
        while (!(bus_if.pix_valid && n == 4) && k < 200) begin
            if (bus_if.pix_valid) n++;
            @(posedge clk); #1;
            k++;
        end
        n_total++;
        if (!(bus_if.pix_valid && n == 4))
            $display("FAIL abort_reach: delivered %0d valid %b want 4 1", n, bus_if.pix_valid);
        else n_pass++;
        bus_if.pix_ready = 1'b0;
        bus_if.abort = 1'b1;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.abort = 1'b0;
        bus_if.start = 1'b0;
        n_total++;
        if (bus_if.pix_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
            $display("FAIL abort_next: valid %b busy %b done %b want 0 0 0",
                     bus_if.pix_valid, bus_if.busy, bus_if.done);
        else n_pass++;
        bad_done = 0; bad_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.done) bad_done++;
            if (bus_if.busy) bad_busy++;
            @(posedge clk); #1;
        end
        n_total++;
        if (bad_done != 0) $display("FAIL abort_nodone: got %0d pulses want 0", bad_done);
        else n_pass++;
        n_total++;
        if (bad_busy != 0) $display("FAIL abort_stay_idle: busy %0d cycles want 0", bad_busy);
        else n_pass++;
        bus_if.pix_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int fd;
        draw(50, 60, 6, 9, 0);
        draw(400, 300, 12, 5, 0);
        build(400, 300, 12, 5);
        fd = first_diff();
        n_total++;
        if (fd != -1)
            $display("FAIL b2b_seq: got %0d px diff@%0d want %0d px",
                     got_q.size(), fd, exp_q.size());
        else n_pass++;
        n_total++;
        if (done_cnt != 1 || busy_after !== 1'b0)
            $display("FAIL b2b_done: done %0d busy_after %b want 1 0", done_cnt, busy_after);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_shapes();
        test_backpressure();
        test_random();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
